// File: rtl/sti_load_sequencer.sv
// ---------------------------------------------------------------------------
// sti_load_sequencer
//   Host-side controller for STI_DAC. Host commands are buffered in a small
//   first-word-fall-through FIFO. Each word gets one load strobe. The
//   sequencer then waits for the matching so_valid burst and checks its
//   length against pi_length. The final word of a frame drives pi_end, and
//   the sequencer then waits for oem_finish before pulsing done.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   cmd_valid/ready   host push handshake (ready = FIFO not full)
//   cmd_data/length/fill/msb/low/last   command payload
//   load              one-cycle load strobe to STI_DAC
//   pi_data/length/fill/msb/low         word presented to STI_DAC, held after load
//   pi_end            high from load of the last word until DONE exits
//   so_valid          serial-valid burst from STI_DAC
//   oem_finish        memory write-back finished (only honoured in FLUSH)
//   busy              FSM not idle
//   done              one-cycle pulse when a frame completes
//   err_timeout       sticky: no burst started within TIMEOUT cycles of load
//   err_len           sticky: burst length differed from 8*(pi_length+1)
//   word_cnt          words sent since reset, wraps
// ---------------------------------------------------------------------------
module sti_load_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_data,
  input  logic [1:0]  cmd_length,
  input  logic        cmd_fill,
  input  logic        cmd_msb,
  input  logic        cmd_low,
  input  logic        cmd_last,
  output logic        load,
  output logic [15:0] pi_data,
  output logic [1:0]  pi_length,
  output logic        pi_fill,
  output logic        pi_msb,
  output logic        pi_low,
  output logic        pi_end,
  input  logic        so_valid,
  input  logic        oem_finish,
  output logic        busy,
  output logic        done,
  output logic        err_timeout,
  output logic        err_len,
  output logic [7:0]  word_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT);

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  length;
    logic        fill;
    logic        msb;
    logic        low;
    logic        last;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT, S_SHIFT, S_GAP, S_FLUSH, S_DONE
  } state_t;

  // ---------------- command FIFO ----------------
  // The head is read combinationally so the FSM can launch a word two cycles
  // after it is pushed; the storage is tiny, so this maps to distributed RAM.
  cmd_t          r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  cmd_t          w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  state_t        r_state;
  logic [TW-1:0] r_tmo;
  logic [5:0]    r_bitcnt;
  logic [5:0]    w_exp_bits;

  assign w_full    = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_head    = r_mem[r_rd_ptr];
  assign w_push    = cmd_valid & ~w_full;
  // A word leaves the FIFO only when the DAC line is quiet.
  assign w_pop     = (r_state == S_IDLE) & ~w_empty & ~so_valid;
  assign cmd_ready = ~w_full;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{data: cmd_data, length: cmd_length, fill: cmd_fill,
                           msb: cmd_msb, low: cmd_low, last: cmd_last};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Expected burst length in bits: 8, 16, 24 or 32.
  assign w_exp_bits = {({1'b0, pi_length} + 3'd1), 3'b000};

  // ---------------- sequencer FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_tmo       <= '0;
      r_bitcnt    <= '0;
      load        <= 1'b0;
      done        <= 1'b0;
      pi_data     <= '0;
      pi_length   <= '0;
      pi_fill     <= 1'b0;
      pi_msb      <= 1'b0;
      pi_low      <= 1'b0;
      pi_end      <= 1'b0;
      err_timeout <= 1'b0;
      err_len     <= 1'b0;
      word_cnt    <= '0;
    end else begin
      load <= 1'b0;
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_state   <= S_LOAD;
            load      <= 1'b1;
            pi_data   <= w_head.data;
            pi_length <= w_head.length;
            pi_fill   <= w_head.fill;
            pi_msb    <= w_head.msb;
            pi_low    <= w_head.low;
            pi_end    <= w_head.last;
          end
        end
        S_LOAD: begin
          r_state <= S_WAIT;
          r_tmo   <= '0;
        end
        S_WAIT: begin
          if (so_valid) begin
            r_state  <= S_SHIFT;
            r_bitcnt <= 6'd1;
          end else if (r_tmo == TW'(TIMEOUT - 1)) begin
            // Abandon the word: not counted, frame end cancelled.
            err_timeout <= 1'b1;
            pi_end      <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_SHIFT: begin
          if (so_valid) begin
            if (r_bitcnt != 6'd63) r_bitcnt <= r_bitcnt + 6'd1;
          end else begin
            if (r_bitcnt != w_exp_bits) err_len <= 1'b1;
            word_cnt <= word_cnt + 8'd1;
            r_state  <= pi_end ? S_FLUSH : S_GAP;
          end
        end
        S_GAP: r_state <= S_IDLE;
        S_FLUSH: begin
          if (oem_finish) begin
            r_state <= S_DONE;
            done    <= 1'b1;
          end
        end
        S_DONE: begin
          pi_end  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_sti_load_sequencer.sv
module tb_sti_load_sequencer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_data;
  logic [1:0]  cmd_length;
  logic        cmd_fill, cmd_msb, cmd_low, cmd_last;
  logic        load;
  logic [15:0] pi_data;
  logic [1:0]  pi_length;
  logic        pi_fill, pi_msb, pi_low, pi_end;
  logic        so_valid, oem_finish;
  logic        busy, done, err_timeout, err_len;
  logic [7:0]  word_cnt;

  sti_load_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cmd_length(cmd_length), .cmd_fill(cmd_fill), .cmd_msb(cmd_msb),
    .cmd_low(cmd_low), .cmd_last(cmd_last),
    .load(load), .pi_data(pi_data), .pi_length(pi_length), .pi_fill(pi_fill),
    .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
    .so_valid(so_valid), .oem_finish(oem_finish),
    .busy(busy), .done(done), .err_timeout(err_timeout), .err_len(err_len),
    .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  // Command plus the DAC behaviour the bench will play back for it.
  typedef struct {
    logic [15:0] data;
    logic [1:0]  len;
    logic        fill, msb, low, last;
    int          n;      // so_valid burst length in cycles
    bit          tmo;    // DAC never answers
    int          d;      // cycles from load to burst start
    int          g;      // cycles from burst end to oem_finish
    bit          spur;   // stray oem_finish outside FLUSH
  } cmd_t;
  typedef struct { cmd_t c; int cyc; int ep; } burst_t;
  typedef struct { int cyc; int kind; int v0; int v1; logic [15:0] data; } chk_t;

  cmd_t   exp_q[$];
  burst_t burst_q[$];
  chk_t   chk_q[$];

  int n_pass = 0, n_total = 0;
  int cyc = 0, epoch = 0;
  int n_acc = 0, n_loads = 0, n_done = 0;
  int model_wc = 0, model_err = 0, model_tmo = 0, model_done = 0;
  int last_drop = -100;
  bit prev_load = 0;
  bit dac_active = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int exp_bits(input logic [1:0] len);
    return 8 * (int'(len) + 1);
  endfunction

  function automatic cmd_t mk(input logic [15:0] data, input logic [1:0] len,
                              input logic last, input int n, input bit tmo);
    cmd_t c;
    c.data = data; c.len = len; c.fill = 1'b0; c.msb = 1'b1; c.low = 1'b0;
    c.last = last; c.n = n; c.tmo = tmo; c.d = 2; c.g = 3; c.spur = 1'b0;
    return c;
  endfunction

  function automatic cmd_t rand_cmd(input bit errs);
    cmd_t c;
    int   e;
    c.data = 16'($urandom);
    c.len  = 2'($urandom_range(0, 3));
    c.fill = 1'($urandom_range(0, 1));
    c.msb  = 1'($urandom_range(0, 1));
    c.low  = 1'($urandom_range(0, 1));
    c.last = ($urandom_range(0, 4) == 0);
    e = exp_bits(c.len);
    c.n = e; c.tmo = 1'b0;
    if (errs) begin
      if ($urandom_range(0, 7) == 0) c.tmo = 1'b1;
      else if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0:       c.n = e - 1;
          1:       c.n = e + 1;
          2:       c.n = e + 5;
          default: c.n = 70;
        endcase
      end
    end
    c.d = $urandom_range(1, 5);
    c.g = $urandom_range(1, 5);
    c.spur = ($urandom_range(0, 3) == 0);
    return c;
  endfunction

  // Called at negedge+1; returns at negedge+1 after the accepting edge.
  task automatic send(input cmd_t c);
    int t = 0;
    bit ok = 0;
    cmd_valid = 1'b1; cmd_data = c.data; cmd_length = c.len;
    cmd_fill = c.fill; cmd_msb = c.msb; cmd_low = c.low; cmd_last = c.last;
    while (!ok && t < 2000) begin
      check("cmd_ready", cmd_ready, ((n_acc - n_loads) < DEPTH));
      if (cmd_ready) begin
        exp_q.push_back(c);
        n_acc++;
        ok = 1;
      end
      @(negedge clk); #1;
      t++;
    end
    if (!ok) check("send_bound", 0, 1);
  endtask

  task automatic drain();
    int t = 0;
    cmd_valid = 1'b0;
    while ((exp_q.size() != 0 || burst_q.size() != 0 || chk_q.size() != 0 ||
            dac_active || busy) && t < 3000) begin
      @(negedge clk); t++;
    end
    check("drain_bound", (t < 3000), 1);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  cmd_t mon_e;
  chk_t mon_k;
  always @(negedge clk) begin
    if (reset) prev_load = 0;
    else begin
      if (load) begin
        n_loads++;
        check("load_width", prev_load, 0);
        check("load_gap", ((cyc - last_drop) >= 3), 1);
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_load: got load=1 expected no queued command");
        end else begin
          mon_e = exp_q.pop_front();
          check("pi_data", pi_data, mon_e.data);
          check("pi_length", pi_length, mon_e.len);
          check("pi_flags", {pi_fill, pi_msb, pi_low}, {mon_e.fill, mon_e.msb, mon_e.low});
          check("pi_end_at_load", pi_end, mon_e.last);
          burst_q.push_back('{c: mon_e, cyc: cyc, ep: epoch});
        end
      end
      prev_load = load;
      while (chk_q.size() != 0 && chk_q[0].cyc <= cyc) begin
        mon_k = chk_q.pop_front();
        if (mon_k.cyc < cyc) check("stale_check_cycle", cyc, mon_k.cyc);
        else if (mon_k.kind == 0) begin
          check("word_cnt", word_cnt, mon_k.v0);
          check("err_len", err_len, mon_k.v1);
          check("pi_data_held", pi_data, mon_k.data);
        end else if (mon_k.kind == 1) begin
          check("err_timeout", err_timeout, mon_k.v0);
        end else begin
          check("done", done, mon_k.v0);
          check("pi_end", pi_end, mon_k.v1);
        end
      end
      if (done) n_done++;
    end
  end

  // ---------------- STI_DAC / memory responder + reference model ----------------
  burst_t dac_b;
  int     dac_l, dac_f, dac_seen;
  initial begin
    so_valid = 1'b0;
    oem_finish = 1'b0;
    forever begin
      @(negedge clk);
      if (burst_q.size() != 0) begin
        dac_b = burst_q.pop_front();
        dac_active = 1;
        dac_l = dac_b.cyc;
        if (dac_b.c.tmo) begin
          // Timeout fires exactly 64 cycles after WAIT is entered.
          chk_q.push_back('{cyc: dac_l + 64, kind: 1, v0: model_tmo, v1: 0, data: 16'h0});
          chk_q.push_back('{cyc: dac_l + 65, kind: 1, v0: 1, v1: 0, data: 16'h0});
          model_tmo = 1;
          while (cyc < dac_l + 65) @(negedge clk);
        end else begin
          while (cyc < dac_l + dac_b.c.d) @(negedge clk);
          so_valid = 1'b1;
          if (dac_b.c.spur && !dac_b.c.last) oem_finish = 1'b1;
          @(negedge clk);
          oem_finish = 1'b0;
          dac_l = cyc - 1;
          while (cyc < dac_l + dac_b.c.n) @(negedge clk);
          so_valid = 1'b0;
          if (epoch == dac_b.ep) begin
            dac_seen = (dac_b.c.n > 63) ? 63 : dac_b.c.n;
            model_wc = (model_wc + 1) % 256;
            if (dac_seen != exp_bits(dac_b.c.len)) model_err = 1;
            last_drop = cyc;
            chk_q.push_back('{cyc: cyc + 1, kind: 0, v0: model_wc, v1: model_err,
                              data: dac_b.c.data});
            if (dac_b.c.last) begin
              dac_f = cyc + dac_b.c.g;
              chk_q.push_back('{cyc: dac_f,     kind: 2, v0: 0, v1: 1, data: 16'h0});
              chk_q.push_back('{cyc: dac_f + 1, kind: 2, v0: 1, v1: 1, data: 16'h0});
              chk_q.push_back('{cyc: dac_f + 2, kind: 2, v0: 0, v1: 0, data: 16'h0});
              model_done++;
              while (cyc < dac_f) @(negedge clk);
              oem_finish = 1'b1;
              @(negedge clk);
              oem_finish = 1'b0;
            end
          end
        end
        dac_active = 0;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- main stimulus ----------------
  int t0, t;
  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_data = '0; cmd_length = '0;
    cmd_fill = 1'b0; cmd_msb = 1'b0; cmd_low = 1'b0; cmd_last = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_load", load, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_errs", {err_timeout, err_len}, 0);
    check("rst_word_cnt", word_cnt, 0);
    check("rst_pi", {pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end}, 0);
    #1 reset = 1'b0;
    @(negedge clk); #1;

    // Single 8-bit word: load two cycles after the push cycle.
    t0 = cyc;
    send(mk(16'hA5C3, 2'd0, 1'b0, 8, 1'b0));
    cmd_valid = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!load && t < 10);
    check("t1_latency", cyc - t0, 2);
    drain();

    // Back-to-back 32-bit words overfill the FIFO.
    repeat (6) send(mk(16'($urandom), 2'd3, 1'b0, 32, 1'b0));
    drain();

    // Clean random traffic.
    for (int i = 0; i < 25; i++) begin
      send(rand_cmd(1'b0));
      cmd_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin @(negedge clk); #1; end
    end
    drain();
    check("clean_err_len", err_len, model_err);
    check("clean_err_timeout", err_timeout, model_tmo);

    // No DAC response: timeout, word not counted.
    send(mk(16'h0F0F, 2'd0, 1'b0, 8, 1'b1));
    drain();
    check("tmo_word_cnt", word_cnt, model_wc);
    check("tmo_busy", busy, 0);

    // 16-bit word with 15-bit burst, then a correct one.
    send(mk(16'h1234, 2'd1, 1'b0, 15, 1'b0));
    send(mk(16'h5678, 2'd1, 1'b0, 16, 1'b0));
    drain();
    check("len_err_sticky", err_len, 1);

    // Last word of a frame, 24-bit.
    send(mk(16'hBEEF, 2'd2, 1'b1, 24, 1'b0));
    drain();

    // Random traffic with length errors and timeouts.
    for (int i = 0; i < 30; i++) begin
      send(rand_cmd(1'b1));
      cmd_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(negedge clk); #1; end
    end
    drain();
    check("final_word_cnt", word_cnt, model_wc);
    check("final_err_len", err_len, model_err);
    check("final_err_timeout", err_timeout, model_tmo);
    check("done_count", n_done, model_done);

    // Reset in the middle of a burst with words queued.
    repeat (4) send(mk(16'($urandom), 2'd3, 1'b0, 32, 1'b0));
    cmd_valid = 1'b0;
    t = 0;
    while (!so_valid && t < 100) begin @(negedge clk); t++; end
    check("rst_test_burst_seen", so_valid, 1);
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    epoch++;
    exp_q.delete(); burst_q.delete(); chk_q.delete();
    n_acc = 0; n_loads = 0; model_wc = 0; model_err = 0; model_tmo = 0;
    @(negedge clk);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    check("mid_rst_load_busy", {load, busy, done}, 0);
    check("mid_rst_errs", {err_timeout, err_len}, 0);
    check("mid_rst_word_cnt", word_cnt, 0);
    check("mid_rst_pi", {pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end}, 0);
    #1 reset = 1'b0;
    repeat (60) @(negedge clk);
    check("no_load_after_reset", n_loads, 0);
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
